// File: rtl/z8_stack_engine_pkg.sv
// rtl/z8_stack_engine_pkg.sv - shared types and constants for the z8 hardware stack
// Contents:
//   WORD_SIZE    default data word width
//   STACK_DEPTH  default number of stack entries
//   STACK_ERR_T  sticky error flag pair {overflow, underflow}
//   STACK_OPS_T  decoded stack request; encoding equals {push_i, pop_i}
package z8_stack_engine_pkg;

   localparam int WORD_SIZE   = 8;
   localparam int STACK_DEPTH = 16;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } STACK_ERR_T;

   typedef enum logic [1:0] {
      STK_NOP     = 2'b00,
      STK_POP     = 2'b01,
      STK_PUSH    = 2'b10,
      STK_REPLACE = 2'b11
   } STACK_OPS_T;

endpackage

// File: rtl/z8_stack_ram.sv
// rtl/z8_stack_ram.sv - DEPTH x WIDTH stack storage, sync write, async read
// Ports:
//   clk    in  1      write clock, rising edge
//   we     in  1      write enable
//   waddr  in  AW     write index
//   wdata  in  WIDTH  write data
//   raddr  in  AW     read index (top of stack)
//   rdata  out WIDTH  combinational read data
module z8_stack_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Contents are deliberately not reset.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/z8_stack_engine.sv
// rtl/z8_stack_engine.sv - parametrised z8 hardware stack with replace-top and sticky errors
// Ports:
//   clk            in  1      clock, rising edge
//   rst            in  1      synchronous active-high reset
//   push_i         in  1      push push_data this cycle
//   pop_i          in  1      pop top entry this cycle
//   push_data      in  WIDTH  value to push
//   clear_err      in  1      clears both sticky error flags
//   top_data       out WIDTH  current top entry, 0 when empty
//   pop_data       out WIDTH  registered popped value
//   pop_valid      out 1      one-cycle strobe aligned with pop_data
//   count          out CW     occupied entries, 0..DEPTH
//   full           out 1      count == DEPTH
//   empty          out 1      count == 0
//   overflow_err   out 1      sticky, set on rejected push
//   underflow_err  out 1      sticky, set on rejected pop
module z8_stack_engine
   import z8_stack_engine_pkg::*;
#(
   parameter int WIDTH = WORD_SIZE,
   parameter int DEPTH = STACK_DEPTH,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_data,
   input  logic             clear_err,
   output logic [WIDTH-1:0] top_data,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             overflow_err,
   output logic             underflow_err
);

   localparam int            IW      = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0]    sp;
   STACK_ERR_T       err;
   STACK_OPS_T       op;
   logic [IW-1:0]    top_idx;
   logic [IW-1:0]    sp_idx;
   logic [IW-1:0]    ram_waddr;
   logic             ram_we;
   logic [WIDTH-1:0] ram_rdata;
   logic             ovf_ev;
   logic             unf_ev;

   assign op    = STACK_OPS_T'({push_i, pop_i});
   assign empty = (sp == '0);
   assign full  = (sp == DEPTH_C);
   assign count = sp;

   // Index math is done at CW bits, then narrowed. The narrowed values are
   // only used when in range (top_idx when non-empty, sp_idx when not full).
   assign top_idx = IW'(sp - CW'(1));
   assign sp_idx  = IW'(sp);

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = sp_idx;
      ovf_ev    = 1'b0;
      unf_ev    = 1'b0;
      case (op)
         STK_PUSH: begin
            if (full) ovf_ev = 1'b1;
            else      ram_we = 1'b1;
         end
         STK_POP: begin
            if (empty) unf_ev = 1'b1;
         end
         STK_REPLACE: begin
            // Overwrite the top in place; when empty the value bypasses storage.
            if (!empty) begin
               ram_we    = 1'b1;
               ram_waddr = top_idx;
            end
         end
         default: ;
      endcase
   end

   z8_stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (IW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (push_data),
      .raddr (top_idx),
      .rdata (ram_rdata)
   );

   assign top_data = empty ? '0 : ram_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         sp        <= '0;
         pop_data  <= '0;
         pop_valid <= 1'b0;
         err       <= '0;
      end else begin
         pop_valid <= 1'b0;
         case (op)
            STK_PUSH: begin
               if (!full) sp <= sp + CW'(1);
            end
            STK_POP: begin
               if (!empty) begin
                  sp        <= sp - CW'(1);
                  pop_data  <= top_data;
                  pop_valid <= 1'b1;
               end
            end
            STK_REPLACE: begin
               pop_data  <= empty ? push_data : top_data;
               pop_valid <= 1'b1;
            end
            default: ;
         endcase
         // A new error event beats a simultaneous clear.
         err.overflow  <= ovf_ev | (err.overflow  & ~clear_err);
         err.underflow <= unf_ev | (err.underflow & ~clear_err);
      end
   end

   assign overflow_err  = err.overflow;
   assign underflow_err = err.underflow;

endmodule

// File: tb/tb_z8_stack_engine.sv
// tb/tb_z8_stack_engine.sv - self-checking scoreboard bench for z8_stack_engine
module tb_z8_stack_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default WIDTH=8, DEPTH=16
   logic       rst = 1'b1;
   logic       push_i = 1'b0, pop_i = 1'b0, clear_err = 1'b0;
   logic [7:0] push_data = '0;
   logic [7:0] top_data, pop_data;
   logic       pop_valid, full, empty, overflow_err, underflow_err;
   logic [4:0] count;

   // Instance B: WIDTH=16, DEPTH=5
   logic        rst2 = 1'b1;
   logic        push2 = 1'b0, pop2 = 1'b0, clear2 = 1'b0;
   logic [15:0] push_data2 = '0;
   logic [15:0] top_data2, pop_data2;
   logic        pop_valid2, full2, empty2, ovf2, unf2;
   logic [2:0]  count2;

   z8_stack_engine dut (
      .clk (clk), .rst (rst), .push_i (push_i), .pop_i (pop_i),
      .push_data (push_data), .clear_err (clear_err),
      .top_data (top_data), .pop_data (pop_data), .pop_valid (pop_valid),
      .count (count), .full (full), .empty (empty),
      .overflow_err (overflow_err), .underflow_err (underflow_err)
   );

   z8_stack_engine #(.WIDTH (16), .DEPTH (5)) dut2 (
      .clk (clk), .rst (rst2), .push_i (push2), .pop_i (pop2),
      .push_data (push_data2), .clear_err (clear2),
      .top_data (top_data2), .pop_data (pop_data2), .pop_valid (pop_valid2),
      .count (count2), .full (full2), .empty (empty2),
      .overflow_err (ovf2), .underflow_err (unf2)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else             n_pass++;
   endtask

   // Reference model state and pop scoreboards
   logic [7:0]  model[$];
   logic [7:0]  sb[$];
   logic        m_ovf = 1'b0, m_unf = 1'b0;
   logic [15:0] sb2[$];

   always @(negedge clk) begin
      if (pop_valid === 1'b1) begin
         if (sb.size() == 0) check("pop_unexpected", 32'(pop_valid), 32'd0);
         else                check("pop_data", 32'(pop_data), 32'(sb.pop_front()));
      end
      if (pop_valid2 === 1'b1) begin
         if (sb2.size() == 0) check("pop2_unexpected", 32'(pop_valid2), 32'd0);
         else                 check("pop2_data", 32'(pop_data2), 32'(sb2.pop_front()));
      end
   end

   task automatic check_state();
      check("count", 32'(count), 32'(model.size()));
      check("top",   32'(top_data), (model.size() > 0) ? 32'(model[$]) : 32'd0);
      check("full",  32'(full),  32'(model.size() == 16));
      check("empty", 32'(empty), 32'(model.size() == 0));
      check("ovf",   32'(overflow_err),  32'(m_ovf));
      check("unf",   32'(underflow_err), 32'(m_unf));
   endtask

   task automatic op(input logic p, input logic q, input logic [7:0] d, input logic clr);
      logic exp_pv;
      logic oe, ue;
      exp_pv = 1'b0; oe = 1'b0; ue = 1'b0;
      push_i = p; pop_i = q; push_data = d; clear_err = clr;
      if (p && !q) begin
         if (model.size() < 16) model.push_back(d);
         else                   oe = 1'b1;
      end else if (!p && q) begin
         if (model.size() > 0) begin sb.push_back(model.pop_back()); exp_pv = 1'b1; end
         else                  ue = 1'b1;
      end else if (p && q) begin
         exp_pv = 1'b1;
         if (model.size() > 0) begin sb.push_back(model[$]); model[$] = d; end
         else                  sb.push_back(d);
      end
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (oe) m_ovf = 1'b1;
      if (ue) m_unf = 1'b1;
      @(posedge clk); #1;
      push_i = 1'b0; pop_i = 1'b0; clear_err = 1'b0;
      @(negedge clk);
      check("pop_valid", 32'(pop_valid), 32'(exp_pv));
      check_state();
   endtask

   task automatic do_reset(input logic with_push, input logic [7:0] d);
      rst = 1'b1; push_i = with_push; push_data = d;
      @(posedge clk); #1;
      rst = 1'b0; push_i = 1'b0;
      model.delete(); sb.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      check("rst_pop_valid", 32'(pop_valid), 32'd0);
      check("rst_pop_data",  32'(pop_data),  32'd0);
      check_state();
   endtask

   task automatic op2(input logic p, input logic q, input logic [15:0] d);
      push2 = p; pop2 = q; push_data2 = d;
      @(posedge clk); #1;
      push2 = 1'b0; pop2 = 1'b0;
      @(negedge clk);
      check("count2_max", 32'(count2 <= 3'd5), 32'd1);
   endtask

   initial begin
      // Reset both instances
      do_reset(1'b0, 8'h00);

      // LIFO order
      op(1, 0, 8'h11, 0); op(1, 0, 8'h22, 0); op(1, 0, 8'h33, 0);
      check("count3", 32'(count), 32'd3);
      op(0, 1, 8'h00, 0); op(0, 1, 8'h00, 0); op(0, 1, 8'h00, 0);
      check("lifo_empty", 32'(empty), 32'd1);

      // Fill to 16, then overflow
      for (int i = 0; i < 16; i++) op(1, 0, 8'(8'h40 + i), 0);
      op(1, 0, 8'hAA, 0);
      check("ovf_top_kept", 32'(top_data), 32'h4F);
      check("ovf_set", 32'(overflow_err), 32'd1);
      op(0, 0, 8'h00, 1);
      check("ovf_cleared", 32'(overflow_err), 32'd0);

      // Replace when full: no overflow, count stays 16
      op(1, 1, 8'h5A, 0);
      check("full_replace_count", 32'(count), 32'd16);

      // Drain, then underflow; clear and error in same cycle -> error wins
      for (int i = 0; i < 16; i++) op(0, 1, 8'h00, 0);
      op(0, 1, 8'h00, 0);
      check("unf_set", 32'(underflow_err), 32'd1);
      op(0, 1, 8'h00, 1);
      check("unf_wins_clear", 32'(underflow_err), 32'd1);
      op(0, 0, 8'h00, 1);

      // Replace-top on [05, 07]
      op(1, 0, 8'h05, 0); op(1, 0, 8'h07, 0);
      op(1, 1, 8'h09, 0);
      check("replace_top", 32'(top_data), 32'h09);
      check("replace_count", 32'(count), 32'd2);
      op(0, 1, 8'h00, 0); op(0, 1, 8'h00, 0);

      // Replace on empty: bypass
      op(1, 1, 8'h3C, 0);
      check("bypass_count", 32'(count), 32'd0);

      // Push then immediate pop of same value
      op(1, 0, 8'h66, 0); op(0, 1, 8'h00, 0);

      // Random mix
      for (int i = 0; i < 80; i++)
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));

      // Reset mid-operation with a push in the reset cycle
      do_reset(1'b0, 8'h00);
      op(1, 0, 8'hA1, 0); op(1, 0, 8'hA2, 0); op(1, 0, 8'hA3, 0);
      do_reset(1'b1, 8'h77);
      check("rst_discard_count", 32'(count), 32'd0);
      op(1, 0, 8'h12, 0); op(0, 1, 8'h00, 0);

      // Instance B: WIDTH=16, DEPTH=5
      rst2 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) op2(1, 0, 16'hBEEF);
      check("b_full", 32'(full2), 32'd1);
      check("b_no_ovf_yet", 32'(ovf2), 32'd0);
      op2(1, 0, 16'hBEEF);
      check("b_ovf", 32'(ovf2), 32'd1);
      check("b_count5", 32'(count2), 32'd5);
      for (int i = 0; i < 5; i++) begin
         sb2.push_back(16'hBEEF);
         op2(0, 1, 16'h0000);
         check("b_pop_valid", 32'(pop_valid2), 32'd1);
      end
      check("b_no_unf_yet", 32'(unf2), 32'd0);
      op2(0, 1, 16'h0000);
      check("b_unf", 32'(unf2), 32'd1);
      check("b_pv_empty", 32'(pop_valid2), 32'd0);
      check("b_count0", 32'(count2), 32'd0);

      @(negedge clk);
      check("sb_drain",  32'(sb.size()),  32'd0);
      check("sb2_drain", 32'(sb2.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
